// File: rtl/fifo_sync_n_if.sv
// Handshake and status bundle for fifo_sync_n: the producer/consumer side is the
// master, the FIFO itself is the slave.
interface fifo_sync_n_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   logic                     enq;
   logic [WIDTH-1:0]         din;
   logic                     deq;
   logic [WIDTH-1:0]         dout;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output enq, din, deq,
      input  dout, full, empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  enq, din, deq,
      output dout, full, empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_n.sv
// Parametrised single-clock FIFO with first-word fall-through output, occupancy
// count, almost-full threshold and registered overflow/underflow pulses.
module fifo_sync_n #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AF_LEVEL = DEPTH - 1
) (
   input  logic          CLK,
   input  logic          RST,
   fifo_sync_n_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [CW-1:0]    cnt;
   logic             ovf_q;
   logic             udf_q;

   logic             full_w;
   logic             empty_w;
   logic             enq_ok;
   logic             deq_ok;

   // Flags decode from the registered count only, so no input reaches an output.
   always_comb begin
      full_w  = (cnt == CW'(DEPTH));
      empty_w = (cnt == '0);
      enq_ok  = bus.enq & (~full_w | bus.deq);
      deq_ok  = bus.deq & ~empty_w;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (enq_ok)
            wp <= wp + AW'(1);
         if (deq_ok)
            rp <= rp + AW'(1);
         cnt   <= cnt + CW'(enq_ok) - CW'(deq_ok);
         ovf_q <= bus.enq & full_w & ~bus.deq;
         udf_q <= bus.deq & empty_w;
      end
   end

   // Storage is deliberately left unreset; pointers and count alone define validity.
   always_ff @(posedge CLK) begin
      if (!RST && enq_ok)
         mem[wp] <= bus.din;
   end

   always_comb begin
      bus.dout        = empty_w ? '0 : mem[rp];
      bus.full        = full_w;
      bus.empty       = empty_w;
      bus.almost_full = (cnt >= CW'(AF_LEVEL));
      bus.count       = cnt;
      bus.overflow    = ovf_q;
      bus.underflow   = udf_q;
   end
endmodule

// File: tb/tb_fifo_sync_n.sv
// Directed and randomised checks of fifo_sync_n against a queue-based reference.
module tb_fifo_sync_n;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AFL   = 3;

   logic CLK;
   logic RST;

   fifo_sync_n_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fifo_sync_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned vectors;
   int unsigned miscompares;

   logic [WIDTH-1:0] q [$];
   bit               m_ovf;
   bit               m_udf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit e, input bit d, input logic [WIDTH-1:0] x, input bit r);
      int sz;
      sz = q.size();
      if (r) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_ovf = e && (sz == DEPTH) && !d;
         m_udf = d && (sz == 0);
         if (d && sz > 0)
            void'(q.pop_front());
         if (e && (sz < DEPTH || d))
            q.push_back(x);
      end
   endtask

   task automatic check_all();
      int sz;
      logic [WIDTH-1:0] head;
      sz   = q.size();
      head = (sz > 0) ? q[0] : '0;
      check("count",       32'(bus.count),       32'(sz));
      check("empty",       32'(bus.empty),       32'(sz == 0));
      check("full",        32'(bus.full),        32'(sz == DEPTH));
      check("almost_full", 32'(bus.almost_full), 32'(sz >= AFL));
      check("dout",        32'(bus.dout),        32'(head));
      check("overflow",    32'(bus.overflow),    32'(m_ovf));
      check("underflow",   32'(bus.underflow),   32'(m_udf));
   endtask

   task automatic cycle(input bit e, input bit d, input logic [WIDTH-1:0] x, input bit r);
      @(negedge CLK);
      bus.enq = e;
      bus.deq = d;
      bus.din = x;
      RST     = r;
      @(posedge CLK);
      model_edge(e, d, x, r);
      #1;
      check_all();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_ovf       = 1'b0;
      m_udf       = 1'b0;
      RST         = 1'b0;
      bus.enq     = 1'b0;
      bus.deq     = 1'b0;
      bus.din     = '0;

      // reset then idle
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);
      check("rst_dout", 32'(bus.dout), 32'h00);

      // fill and overfill
      cycle(1, 0, 8'h11, 0);
      cycle(1, 0, 8'h22, 0);
      cycle(1, 0, 8'h33, 0);
      check("af_at3",   32'(bus.almost_full), 32'd1);
      check("full_at3", 32'(bus.full),        32'd0);
      cycle(1, 0, 8'h44, 0);
      check("full_at4", 32'(bus.full), 32'd1);
      cycle(1, 0, 8'h55, 0);
      check("ovf_pulse", 32'(bus.overflow), 32'd1);
      cycle(0, 0, 8'h00, 0);
      check("ovf_clear", 32'(bus.overflow), 32'd0);
      check("head_11",   32'(bus.dout),     32'h11);
      for (int i = 0; i < 4; i++)
         cycle(0, 1, 8'h00, 0);
      check("drained_empty", 32'(bus.empty), 32'd1);

      // underflow, then enq+deq on empty
      cycle(0, 1, 8'h00, 0);
      check("udf_pulse", 32'(bus.underflow), 32'd1);
      cycle(1, 1, 8'hA5, 0);
      check("udf_enq_dout", 32'(bus.dout), 32'hA5);
      cycle(0, 0, 8'h00, 0);
      cycle(0, 1, 8'h00, 0);

      // full with simultaneous enq+deq
      for (int i = 1; i <= 4; i++)
         cycle(1, 0, 8'(i), 0);
      cycle(1, 1, 8'h05, 0);
      check("full_swap_head", 32'(bus.dout), 32'h02);
      for (int i = 0; i < 4; i++)
         cycle(0, 1, 8'h00, 0);

      // wrap-around at count 2
      cycle(1, 0, 8'h80, 0);
      cycle(1, 0, 8'h81, 0);
      for (int i = 0; i < 10; i++)
         cycle(1, 1, 8'(8'h82 + i), 0);
      check("wrap_head", 32'(bus.dout), 32'h8A);
      cycle(0, 1, 8'h00, 0);
      cycle(0, 1, 8'h00, 0);

      // reset mid-operation overrides enq
      cycle(1, 0, 8'h61, 0);
      cycle(1, 0, 8'h62, 0);
      cycle(1, 0, 8'h63, 0);
      cycle(1, 0, 8'h99, 1);
      check("midrst_count", 32'(bus.count), 32'd0);
      cycle(1, 0, 8'h7E, 0);
      check("post_rst_dout", 32'(bus.dout), 32'h7E);

      // randomised traffic with occasional reset
      for (int i = 0; i < 400; i++)
         cycle(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
               8'($urandom), bit'($urandom_range(0, 59) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
